// File: rtl/lcd_frame_writer.sv
// lcd_frame_writer: HD44780 16x2 power-up/init, then endless two-line
// refresh from a latched 256-bit frame, with hex-digit to ASCII mapping.
// Ports: iCLK_50MHZ, iRST_N (async, low), dataLCD[255:0] frame in;
//        DATA_BUS[7:0] (always driven), LCD_RW (0), LCD_E, LCD_RS out;
//        oINIT_DONE (sticky), oFRAME_DONE (1-cycle pulse) out.
// Option: define LCD_FRAME_CMP_EN to hold off refresh while the frame
//         matches the last snapshot.
module lcd_frame_writer #(
  parameter int PWRUP_WAIT_CYC = 750000,
  parameter int E_SETUP_CYC    = 4,
  parameter int E_PULSE_CYC    = 16,
  parameter int E_HOLD_CYC     = 4,
  parameter int CMD_WAIT_CYC   = 2500,
  parameter int CLEAR_WAIT_CYC = 100000
) (
  input  logic         iCLK_50MHZ,
  input  logic         iRST_N,
  input  logic [255:0] dataLCD,
  inout  wire  [7:0]   DATA_BUS,
  output logic         LCD_RW,
  output logic         LCD_E,
  output logic         LCD_RS,
  output logic         oINIT_DONE,
  output logic         oFRAME_DONE
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAXP = max2(
    max2(max2(PWRUP_WAIT_CYC, E_SETUP_CYC), max2(E_PULSE_CYC, E_HOLD_CYC)),
    max2(CMD_WAIT_CYC, CLEAR_WAIT_CYC));
  localparam int CW = $clog2(MAXP + 1);

  localparam logic [CW-1:0] PWRUP_LAST = CW'(PWRUP_WAIT_CYC - 1);
  localparam logic [CW-1:0] SETUP_LAST = CW'(E_SETUP_CYC - 1);
  localparam logic [CW-1:0] PULSE_LAST = CW'(E_PULSE_CYC - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(E_HOLD_CYC - 1);
  localparam logic [CW-1:0] CMD_LAST   = CW'(CMD_WAIT_CYC - 1);
  localparam logic [CW-1:0] CLEAR_LAST = CW'(CLEAR_WAIT_CYC - 1);

  typedef enum logic [2:0] {
    S_PWRUP, S_INIT, S_ADDR1, S_LINE1, S_ADDR2, S_LINE2
  } state_t;

  typedef enum logic [1:0] {
    T_SETUP, T_PULSE, T_HOLD, T_WAIT
  } xfer_t;

  state_t         state;
  xfer_t          xs;
  logic           busy;
  logic [CW-1:0]  cnt;
  logic [3:0]     idx;
  logic [255:0]   snap;
  logic [7:0]     bus_q;
  logic [CW-1:0]  wait_last;

  function automatic logic [7:0] xlate(input logic [7:0] b);
    if (b < 8'h0A)      return 8'h30 + b;
    else if (b < 8'h10) return 8'h37 + b;
    else                return b;
  endfunction

  // Byte for (line, col) of the snapshot, already translated.
  function automatic logic [7:0] pick(
    input logic [255:0] f,
    input logic         line,
    input logic [3:0]   col
  );
    logic [255:0] s;
    s = f << {line, col, 3'b000};
    return xlate(s[255:248]);
  endfunction

  function automatic logic [7:0] init_cmd(input logic [1:0] i);
    case (i)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction

  assign DATA_BUS = bus_q;
  assign LCD_RW   = 1'b0;

  // Clear needs the long settle; data bytes never take it.
  assign wait_last = (!LCD_RS && bus_q == 8'h01) ? CLEAR_LAST : CMD_LAST;

  always_ff @(posedge iCLK_50MHZ or negedge iRST_N) begin
    if (!iRST_N) begin
      state       <= S_PWRUP;
      xs          <= T_SETUP;
      busy        <= 1'b0;
      cnt         <= '0;
      idx         <= '0;
      snap        <= {32{8'h20}};
      bus_q       <= 8'h00;
      LCD_RS      <= 1'b0;
      LCD_E       <= 1'b0;
      oINIT_DONE  <= 1'b0;
      oFRAME_DONE <= 1'b0;
    end else begin
      oFRAME_DONE <= 1'b0;
      if (!busy) begin
        if (state == S_PWRUP) begin
          if (cnt == PWRUP_LAST) begin
            state  <= S_INIT;
            idx    <= '0;
            busy   <= 1'b1;
            cnt    <= '0;
            xs     <= T_SETUP;
            bus_q  <= 8'h38;
            LCD_RS <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
`ifdef LCD_FRAME_CMP_EN
        end else if (dataLCD != snap) begin
          snap   <= dataLCD;
          busy   <= 1'b1;
          cnt    <= '0;
          xs     <= T_SETUP;
          bus_q  <= 8'h80;
          LCD_RS <= 1'b0;
`endif
        end
      end else begin
        unique case (xs)
          T_SETUP: begin
            if (cnt == SETUP_LAST) begin
              xs    <= T_PULSE;
              LCD_E <= 1'b1;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          T_PULSE: begin
            if (cnt == PULSE_LAST) begin
              xs    <= T_HOLD;
              LCD_E <= 1'b0;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          T_HOLD: begin
            if (cnt == HOLD_LAST) begin
              xs  <= T_WAIT;
              cnt <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          T_WAIT: begin
            if (cnt == wait_last) begin
              cnt <= '0;
              xs  <= T_SETUP;
              case (state)
                S_INIT: begin
                  if (idx == 4'd3) begin
                    oINIT_DONE <= 1'b1;
                    state      <= S_ADDR1;
                    snap       <= dataLCD;
                    bus_q      <= 8'h80;
                    LCD_RS     <= 1'b0;
                  end else begin
                    idx    <= idx + 4'd1;
                    bus_q  <= init_cmd(idx[1:0] + 2'd1);
                    LCD_RS <= 1'b0;
                  end
                end
                S_ADDR1: begin
                  state  <= S_LINE1;
                  idx    <= '0;
                  bus_q  <= pick(snap, 1'b0, 4'd0);
                  LCD_RS <= 1'b1;
                end
                S_LINE1: begin
                  if (idx == 4'd15) begin
                    state  <= S_ADDR2;
                    bus_q  <= 8'hC0;
                    LCD_RS <= 1'b0;
                  end else begin
                    idx    <= idx + 4'd1;
                    bus_q  <= pick(snap, 1'b0, idx + 4'd1);
                    LCD_RS <= 1'b1;
                  end
                end
                S_ADDR2: begin
                  state  <= S_LINE2;
                  idx    <= '0;
                  bus_q  <= pick(snap, 1'b1, 4'd0);
                  LCD_RS <= 1'b1;
                end
                S_LINE2: begin
                  if (idx == 4'd15) begin
                    oFRAME_DONE <= 1'b1;
                    state       <= S_ADDR1;
`ifdef LCD_FRAME_CMP_EN
                    busy        <= 1'b0;
`else
                    snap        <= dataLCD;
                    bus_q       <= 8'h80;
                    LCD_RS      <= 1'b0;
`endif
                  end else begin
                    idx    <= idx + 4'd1;
                    bus_q  <= pick(snap, 1'b1, idx + 4'd1);
                    LCD_RS <= 1'b1;
                  end
                end
                default: busy <= 1'b0;
              endcase
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lcd_frame_writer.sv
// tb_lcd_frame_writer: cycle-level reference model of the LCD bus waveform
// plus directed literal checks of init, frame content, tearing and reset.
module tb_lcd_frame_writer;

  localparam int PW  = 20;
  localparam int ES  = 2;
  localparam int EP  = 4;
  localparam int EH  = 2;
  localparam int CWT = 8;
  localparam int CL  = 30;

  localparam logic [255:0] FRAME_A = {
    "BIOS", {12{8'h20}},
    "Output: ", 8'h01, 8'h02, 8'h03, 8'h0A, {4{8'h20}}};
  localparam logic [255:0] FRAME_B = {
    "HELLO", {11{8'h20}},
    "Output: ", 8'h0F, 8'h7E, 8'h09, 8'h10, {4{8'h20}}};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [255:0] din;
  wire  [7:0]   data_bus;
  logic         rw, e, rs, init_done, frame_done;

  always #5 clk = ~clk;

  lcd_frame_writer #(
    .PWRUP_WAIT_CYC(PW), .E_SETUP_CYC(ES), .E_PULSE_CYC(EP),
    .E_HOLD_CYC(EH), .CMD_WAIT_CYC(CWT), .CLEAR_WAIT_CYC(CL)
  ) dut (
    .iCLK_50MHZ(clk), .iRST_N(rst_n), .dataLCD(din),
    .DATA_BUS(data_bus), .LCD_RW(rw), .LCD_E(e), .LCD_RS(rs),
    .oINIT_DONE(init_done), .oFRAME_DONE(frame_done)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  int           cyc;
  logic [255:0] din_edge;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  always @(posedge clk) din_edge <= din;

  // Reference model: queue of pending transfers, timing by arithmetic.
  localparam int PH_PWR  = 0;
  localparam int PH_INIT = 1;
  localparam int PH_FRM  = 2;
  localparam int PH_IDLE = 3;

  logic [8:0]   q[$];
  int           m_phase, m_start, m_len, off;
  logic         m_rs, m_init, m_fd, m_e;
  logic [7:0]   m_byte;
  logic [255:0] m_snap;

  function automatic logic [7:0] ascii(input logic [7:0] b);
    if (b <= 8'd9)  return 8'h30 + b;
    if (b <= 8'd15) return 8'h41 + (b - 8'd10);
    return b;
  endfunction

  task automatic push_frame(input logic [255:0] f);
    q.push_back({1'b0, 8'h80});
    for (int c = 0; c < 16; c++) q.push_back({1'b1, ascii(f[255-8*c -: 8])});
    q.push_back({1'b0, 8'hC0});
    for (int c = 0; c < 16; c++) q.push_back({1'b1, ascii(f[127-8*c -: 8])});
  endtask

  task automatic start_next();
    {m_rs, m_byte} = q.pop_front();
    m_start = cyc;
    m_len = ES + EP + EH + ((!m_rs && m_byte == 8'h01) ? CL : CWT);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      m_phase = PH_PWR;
      q.delete();
      m_rs = 1'b0; m_byte = 8'h00; m_init = 1'b0; m_fd = 1'b0;
      m_start = 0; m_len = 0;
    end else begin
      m_fd = 1'b0;
      if (m_phase == PH_PWR && cyc == PW) begin
        q.push_back({1'b0, 8'h38}); q.push_back({1'b0, 8'h0C});
        q.push_back({1'b0, 8'h01}); q.push_back({1'b0, 8'h06});
        m_phase = PH_INIT;
        start_next();
      end else if ((m_phase == PH_INIT || m_phase == PH_FRM) &&
                   cyc == m_start + m_len) begin
        if (q.size() == 0) begin
          if (m_phase == PH_INIT) m_init = 1'b1;
          else                    m_fd = 1'b1;
`ifdef LCD_FRAME_CMP_EN
          if (m_phase == PH_FRM) m_phase = PH_IDLE;
          else begin
            m_phase = PH_FRM; m_snap = din_edge; push_frame(m_snap);
          end
`else
          m_phase = PH_FRM; m_snap = din_edge; push_frame(m_snap);
`endif
        end
        if (q.size() != 0) start_next();
      end else if (m_phase == PH_IDLE && din_edge != m_snap) begin
        m_phase = PH_FRM; m_snap = din_edge; push_frame(m_snap);
        start_next();
      end
      off = cyc - m_start;
      m_e = (m_phase == PH_INIT || m_phase == PH_FRM) &&
            off >= ES && off < ES + EP;
      chk($sformatf("bus_cyc%0d", cyc),
          {19'd0, e, rs, data_bus, rw, init_done, frame_done},
          {19'd0, m_e, m_rs, m_byte, 1'b0, m_init, m_fd});
    end
  end

  // Capture of every LCD_E rising edge and of status edges since reset.
  logic [7:0] cap_b [0:511];
  logic       cap_rs[0:511];
  int         cap_t [0:511];
  int         cap_n, rises, first_rise, init_edge, fd_edge;
  logic       e_prev, ini_prev;

  always @(negedge clk) begin
    if (!rst_n) begin
      cap_n = 0; rises = 0; first_rise = -1; init_edge = -1; fd_edge = -1;
      e_prev = 1'b0; ini_prev = 1'b0;
    end else begin
      if (e && !e_prev) begin
        if (cap_n < 512) begin
          cap_b[cap_n] = data_bus; cap_rs[cap_n] = rs; cap_t[cap_n] = cyc;
        end
        cap_n++;
        rises++;
        if (first_rise < 0) first_rise = cyc;
      end
      if (init_done && !ini_prev && init_edge < 0) init_edge = cyc;
      if (frame_done && fd_edge < 0) fd_edge = cyc;
      e_prev = e;
      ini_prev = init_done;
    end
  end

  task automatic wait_cyc(input int n);
    int b;
    b = 0;
    while (cyc < n && b < 5000) begin
      @(posedge clk); #1;
      b++;
    end
    if (cyc < n) begin
      checks++; errors++;
      $display("FAIL wait_cyc actual=%0d required=%0d", cyc, n);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  int r0;

  initial begin
    din = FRAME_A;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {e, rs, data_bus, rw, init_done, frame_done}, 0);
    #2 rst_n = 1'b1;

    // Change frame while column 0 of line 1 is in flight.
    wait_cyc(130);
    #2 din = FRAME_B;

    wait_cyc(700);
    chk("first_e_rise", first_rise, 22);
    chk("init_cmd0", cap_b[0], 8'h38);
    chk("init_cmd1", cap_b[1], 8'h0C);
    chk("init_cmd2", cap_b[2], 8'h01);
    chk("init_cmd3", cap_b[3], 8'h06);
    chk("init_rs", cap_rs[3], 1'b0);
    chk("clear_rise", cap_t[2], 54);
    chk("after_clear_rise", cap_t[3], 92);
    chk("init_done_edge", init_edge, 106);
    chk("frame_done_edge", fd_edge, 650);
    chk("addr1", cap_b[4], 8'h80);
    chk("addr1_rs", cap_rs[4], 1'b0);
    chk("l1c0", cap_b[5], 8'h42);
    chk("l1c0_rs", cap_rs[5], 1'b1);
    chk("l1c1_old", cap_b[6], 8'h49);
    chk("l1c3_old", cap_b[8], 8'h53);
    chk("addr2", cap_b[21], 8'hC0);
    chk("addr2_rs", cap_rs[21], 1'b0);
    chk("l2c0", cap_b[22], 8'h4F);
    chk("l2c8_hex1", cap_b[30], 8'h31);
    chk("l2c9_hex2", cap_b[31], 8'h32);
    chk("l2c10_hex3", cap_b[32], 8'h33);
    chk("l2c11_hexA", cap_b[33], 8'h41);
    chk("l2c12_space", cap_b[34], 8'h20);
    chk("next_addr1", cap_b[38], 8'h80);

    wait_cyc(1200);
    chk("f2_l1c0_new", cap_b[39], 8'h48);
    chk("f2_l1c1_new", cap_b[40], 8'h45);
    chk("f2_hexF", cap_b[64], 8'h46);
    chk("f2_pass7E", cap_b[65], 8'h7E);
    chk("f2_hex9", cap_b[66], 8'h39);
    chk("f2_pass10", cap_b[67], 8'h10);

`ifdef LCD_FRAME_CMP_EN
    r0 = rises;
    wait_cyc(3195);
    chk("idle_no_e", rises - r0, 0);
    #2 din[0] = ~din[0];
    wait_cyc(3200);
    chk("restart_addr", cap_b[72], 8'h80);
    chk("restart_edge", cap_t[72], 3198);
`else
    // Reset while E is high in line 2 of the third frame.
    wait_cyc(1485);
    chk("pre_reset_e", e, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset", {e, rs, data_bus, rw, init_done, frame_done}, 0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    wait_cyc(700);
    r0 = first_rise;
    chk("rerun_first_e", r0, 22);
    chk("rerun_init_edge", init_edge, 106);
    chk("rerun_fd_edge", fd_edge, 650);
    chk("rerun_cmd0", cap_b[0], 8'h38);
    chk("rerun_addr1", cap_b[4], 8'h80);
    chk("rerun_l1c0", cap_b[5], 8'h48);
    chk("rerun_l1c1", cap_b[6], 8'h45);
`endif

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
